// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin arbiter driving a shared 8:1 bit mux.
// A grant lasts up to MAX_HOLD cycles. When a grant ends, the next requester
// is chosen from the one after the outgoing requester, with no idle cycle.
module mux8_rr_scheduler #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       data_out
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr,   w_ptr_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [7:0] r_gnt,   w_gnt_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  logic       r_busy,  w_busy_nxt;

  logic [3:0] w_idle_pick;
  logic [3:0] w_rel_pick;
  logic       w_release;

  // Round-robin search: {found, index} of the first set bit at start, start+1, ... mod 8.
  function automatic logic [3:0] f_search(input logic [7:0] v, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    // Walk from the farthest slot back to start so that the nearest hit wins.
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] f_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

  assign w_idle_pick = f_search(req, r_ptr);
  assign w_rel_pick  = f_search(req, r_sel + 3'd1);
  assign w_release   = !req[r_sel] || (r_cnt >= HOLD_LIM);

  // State register: FSM state, pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 3'd0;
      r_cnt   <= 8'd0;
      r_gnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic: start, hold, hand over or drop the grant.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_idle_pick[3]) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = f_onehot(w_idle_pick[2:0]);
          w_sel_nxt   = w_idle_pick[2:0];
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 8'd1;
        end else begin
          w_gnt_nxt  = 8'd0;
          w_busy_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!w_release) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else begin
          // The pointer always moves past the outgoing requester, even when it is re-granted.
          w_ptr_nxt = r_sel + 3'd1;
          if (w_rel_pick[3]) begin
            w_gnt_nxt = f_onehot(w_rel_pick[2:0]);
            w_sel_nxt = w_rel_pick[2:0];
            w_cnt_nxt = 8'd1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 8'd0;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 8'd0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output logic: registered grant outputs plus the gated mux data path.
  always_comb begin
    gnt      = r_gnt;
    sel      = r_sel;
    busy     = r_busy;
    data_out = data_in[r_sel] & r_busy;
  end

endmodule
